// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the register-file write port.
// WB has fixed priority; a wait counter bounds starvation of the long-latency unit.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  regWrite,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  grant_id
);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_inc;
  logic       grant0;
  logic       grant1;
  logic       xfer0;
  logic       xfer1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state)
      NORMAL: begin
        grant0 = req0_valid;
        grant1 = !req0_valid && req1_valid;
      end
      FORCE1: begin
        grant1 = req1_valid;
      end
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign req0_ready = req0_valid && grant0;
  assign req1_ready = req1_valid && grant1;
  assign xfer0      = req0_ready;
  assign xfer1      = req1_ready;
  assign wait_inc   = wait_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      wait_cnt   <= 4'd0;
      regWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      grant_id   <= 1'b0;
    end else begin
      // Writes to r0 are accepted but never reach the file
      if (xfer0) begin
        regWrite   <= |req0_reg;
        write_reg  <= req0_reg;
        write_data <= req0_data;
        grant_id   <= 1'b0;
      end else if (xfer1) begin
        regWrite   <= |req1_reg;
        write_reg  <= req1_reg;
        write_data <= req1_data;
        grant_id   <= 1'b1;
      end else begin
        regWrite   <= 1'b0;
      end

      unique case (state)
        NORMAL: begin
          if (req1_valid && !grant1) begin
            wait_cnt <= wait_inc;
            if (wait_inc == MAX_W) begin
              state <= FORCE1;
            end
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        FORCE1: begin
          if (!req1_valid || xfer1) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
          end
        end
        default: begin
          state    <= NORMAL;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic [AW-1:0] req0_reg;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_reg;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          regWrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          grant_id;

  regfile_write_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_WAIT  (MW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_reg  (req0_reg),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_reg  (req1_reg),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .regWrite  (regWrite),
    .write_reg (write_reg),
    .write_data(write_data),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: how long the pending req1 has been refused, plus expected port
  int            m_wait;
  logic          m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  logic          m_gid;
  logic [DW-1:0] dut_rf [32];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait  = 0;
    m_rw    = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    m_gid   = 1'b0;
  endtask

  task automatic step(output logic a0, output logic a1);
    logic f;
    logic g0;
    logic g1;
    #1;
    f  = req1_valid && (m_wait >= MW);
    g0 = req0_valid && !f;
    g1 = req1_valid && (f || !req0_valid);
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    if (regWrite) dut_rf[write_reg] = write_data;
    @(posedge clk);
    if (g0) begin
      m_rw = (req0_reg != 0); m_wreg = req0_reg;
      m_wdata = req0_data; m_gid = 1'b0;
    end else if (g1) begin
      m_rw = (req1_reg != 0); m_wreg = req1_reg;
      m_wdata = req1_data; m_gid = 1'b1;
    end else begin
      m_rw = 1'b0;
    end
    m_wait = (req1_valid && !g1) ? m_wait + 1 : 0;
    #1;
    check("regWrite", regWrite, m_rw);
    check("write_reg", write_reg, m_wreg);
    check("write_data", write_data, m_wdata);
    check("grant_id", grant_id, m_gid);
    a0 = g0;
    a1 = g1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic a0, a1;
    int pulses;
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    model_reset();
    #23;
    check("rst_regWrite", regWrite, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_grant_id", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset in the middle of a transfer to r5
    req0_valid = 1'b1; req0_reg = 5; req0_data = 32'hA5A5_0005;
    step(a0, a1);
    check("pre_rst_rw", regWrite, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rw", regWrite, 0);
    check("async_rst_reg", write_reg, 0);
    check("async_rst_gid", grant_id, 0);
    model_reset();
    req1_valid = 1'b1; req1_reg = 6; req1_data = 32'h66;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy0", req0_ready, 1);
    check("post_rst_rdy1", req1_ready, 0);
    step(a0, a1);
    req0_valid = 1'b0;
    step(a0, a1);
    idle();
    step(a0, a1);

    // single source
    req0_valid = 1'b1; req0_reg = 3; req0_data = 32'hDEAD_BEEF;
    #1;
    check("single_rdy0", req0_ready, 1);
    step(a0, a1);
    idle();
    check("single_rw", regWrite, 1);
    check("single_reg", write_reg, 3);
    check("single_data", write_data, 32'hDEAD_BEEF);
    check("single_gid", grant_id, 0);
    step(a0, a1);
    check("single_rw_off", regWrite, 0);

    // starvation bound
    req0_valid = 1'b1; req0_reg = 1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 7; req1_data = 32'h1234_5678;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("starve_rdy1", req1_ready, c == 4);
      check("starve_rdy0", req0_ready, c != 4);
      step(a0, a1);
      if (c == 4) begin
        check("starve_wreg", write_reg, 7);
        check("starve_gid", grant_id, 1);
        req1_valid = 1'b0;
      end
    end
    idle();
    step(a0, a1);

    // register 0 from req1
    req1_valid = 1'b1; req1_reg = 0; req1_data = 32'hFFFF_FFFF;
    #1;
    check("r0_rdy1", req1_ready, 1);
    step(a0, a1);
    check("r0_rw", regWrite, 0);
    check("r0_gid", grant_id, 1);
    req0_valid = 1'b1; req0_reg = 2; req0_data = 32'h22;
    req1_reg = 4; req1_data = 32'h44;
    #1;
    check("r0_normal_rdy0", req0_ready, 1);
    check("r0_normal_rdy1", req1_ready, 0);
    step(a0, a1);
    req0_valid = 1'b0;
    step(a0, a1);
    idle();
    step(a0, a1);

    // same destination from both sources
    req0_valid = 1'b1; req0_reg = 9; req0_data = 32'h1;
    req1_valid = 1'b1; req1_reg = 9; req1_data = 32'h2;
    step(a0, a1);
    req0_valid = 1'b0;
    check("same_first", write_data, 1);
    step(a0, a1);
    idle();
    check("same_second", write_data, 2);
    step(a0, a1);
    check("same_r9", dut_rf[9], 32'h2);

    // back-to-back throughput
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      req0_valid = 1'b1; req0_reg = AW'(i); req0_data = 32'h100 + i;
      step(a0, a1);
      if (regWrite) pulses++;
      check("tput_reg", write_reg, i);
    end
    idle();
    check("tput_pulses", pulses, 16);
    step(a0, a1);

    // randomized protocol-compliant traffic
    for (int n = 0; n < 600; n++) begin
      if (!req0_valid || a0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_reg   = AW'($urandom_range(0, 31));
        req0_data  = $urandom;
      end
      if (!req1_valid || a1) begin
        req1_valid = ($urandom_range(0, 2) == 0);
        req1_reg   = AW'($urandom_range(0, 31));
        req1_data  = $urandom;
      end
      step(a0, a1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
